// File: rtl/elm_pkg.sv
// Shared constants for the ELM hidden neuron: state encoding, default Q format
// and the saturation limits of the default data and accumulator widths.
package elm_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam logic signed [DATA_WIDTH-1:0] DW_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DW_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
endpackage

// File: rtl/elm_sat_add.sv
// Signed W-bit adder that clamps to the W-bit signed range on overflow.
module elm_sat_add
    import elm_pkg::*;
#(
    parameter int W = ACC_WIDTH
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);
    logic signed [W-1:0] raw;

    always_comb begin
        raw = a + b;
        sum = raw;
        // Overflow only when both operands share a sign the result lacks.
        if ((a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]))
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
endmodule

// File: rtl/elm_hidden_neuron.sv
// One ELM hidden-layer neuron: streams inputs against a 1-cycle-latency weight
// memory, saturating MAC, bias, rescale. Define ELM_RELU_EN for ReLU output.
module elm_hidden_neuron
    import elm_pkg::*;
#(
    parameter int layerNo      = 1,
    parameter int neuronNo     = 10,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = DATA_WIDTH,
    parameter int fracBits     = FRAC_BITS,
    parameter logic signed [dataWidth-1:0] BIAS = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [dataWidth-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        ren,
    output logic [addressWidth:0]       raddr,
    input  logic signed [dataWidth-1:0] wout,
    output logic signed [dataWidth-1:0] out_data,
    output logic                        out_valid
);
    localparam int AW = addressWidth + 1;
    localparam int PW = 2 * dataWidth;

    localparam logic [AW-1:0]          CNT_LAST = AW'(numWeight - 1);
    localparam logic signed [PW-1:0]   BIAS_EXT = PW'(BIAS);
    localparam logic signed [PW-1:0]   ACC_INIT = BIAS_EXT <<< fracBits;
    localparam logic signed [dataWidth-1:0] OMAX = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic signed [dataWidth-1:0] OMIN = {1'b1, {(dataWidth-1){1'b0}}};
    localparam logic signed [PW-1:0]   OMAX_EXT = PW'(OMAX);
    localparam logic signed [PW-1:0]   OMIN_EXT = PW'(OMIN);

    if (numWeight < 1 || numWeight > 2**AW || layerNo < 0 || neuronNo < 0) begin : g_param_check
        $error("elm_hidden_neuron: illegal parameter set");
    end

    logic [1:0]                 state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic                       in_ready_q, in_ready_d;
    logic                       drain_q, drain_d;
    logic signed [dataWidth-1:0] x_q, x_d;
    logic [1:0]                 vld_q, vld_d;
    logic signed [PW-1:0]       prod_q, prod_d;
    logic signed [PW-1:0]       acc_q, acc_d;
    logic signed [dataWidth-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;

    logic                       accept;
    logic signed [PW-1:0]       acc_sum;
    logic signed [PW-1:0]       acc_shr;
    logic signed [dataWidth-1:0] out_final;

    assign accept    = in_valid & in_ready_q;
    assign ren       = accept;
    assign raddr     = cnt_q;
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    elm_sat_add #(.W(PW)) u_sat_add (
        .a   (acc_q),
        .b   (prod_q),
        .sum (acc_sum)
    );

    // Rescale the accumulator back to the data Q format and clamp.
    always_comb begin
        acc_shr = acc_q >>> fracBits;
        if (acc_shr > OMAX_EXT)
            out_final = OMAX;
        else if (acc_shr < OMIN_EXT)
            out_final = OMIN;
        else
            out_final = acc_shr[dataWidth-1:0];
`ifdef ELM_RELU_EN
        if (out_final[dataWidth-1])
            out_final = '0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        drain_d     = drain_q;
        x_d         = x_q;
        vld_d       = {vld_q[0], accept};
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        if (accept) begin
            x_d = in_data;
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                state_d    = ST_DRAIN;
                in_ready_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Weight arrives one cycle after the read; bubbles never reach acc.
        if (vld_q[0])
            prod_d = x_q * wout;
        if (vld_q[1])
            acc_d = acc_sum;

        case (state_q)
            ST_ACC: ;
            ST_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q)
                    state_d = ST_FINAL;
            end
            ST_FINAL: begin
                out_data_d  = out_final;
                out_valid_d = 1'b1;
                acc_d       = ACC_INIT;
                in_ready_d  = 1'b1;
                state_d     = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            drain_q     <= 1'b0;
            x_q         <= '0;
            vld_q       <= '0;
            prod_q      <= '0;
            acc_q       <= ACC_INIT;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            drain_q     <= drain_d;
            x_q         <= x_d;
            vld_q       <= vld_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
